// File: rtl/ser_port_arb.sv
// ser_port_arb: round-robin arbiter sharing one serializer input port
// between NUM_REQ cache-bank requesters. The winner is captured into a
// registered output stage that drains under ser_full backpressure.
// Optional build macro SER_PORT_ARB_WB_PRIO_EN: writeback/extract requests
// (req_wb=1) win over reads, while one round-robin pointer is shared by both.
module ser_port_arb #(
    parameter int NUM_REQ = 4,
    parameter int PKT_W   = 160,
    parameter int SRC_W   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_wb,
    input  logic [NUM_REQ*PKT_W-1:0] req_pkt,
    output logic [NUM_REQ-1:0]       req_ack,
    output logic [NUM_REQ-1:0]       bank_full,
    input  logic                     ser_full,
    output logic                     out_valid,
    output logic [PKT_W-1:0]         out_pkt,
    output logic [SRC_W-1:0]         out_src,
    output logic                     out_wb
);

    logic               out_valid_reg;
    logic [PKT_W-1:0]   out_pkt_reg;
    logic [SRC_W-1:0]   out_src_reg;
    logic               out_wb_reg;
    logic [SRC_W-1:0]   rr_ptr_reg;
    logic [SRC_W-1:0]   rr_ptr_next;

    logic               cap_en;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] at_or_above_ptr;
    logic [NUM_REQ-1:0] elig_hi;
    logic [NUM_REQ-1:0] pick_src;
    logic [NUM_REQ-1:0] grant_oh;
    logic               grant_any;
    logic [SRC_W-1:0]   winner;
    logic [PKT_W-1:0]   win_pkt;
    logic               win_wb;

    // Selection chains: OR-accumulate the one-hot winner's packet and index
    logic [PKT_W-1:0]   pkt_chain [NUM_REQ+1];
    logic [SRC_W-1:0]   src_chain [NUM_REQ+1];

    // The output register may take a new packet when empty or draining now
    assign cap_en = ~out_valid_reg | ~ser_full;

`ifdef SER_PORT_ARB_WB_PRIO_EN
    logic [NUM_REQ-1:0] wb_req;
    assign wb_req = req_valid & req_wb;
    assign elig   = (|wb_req) ? wb_req : req_valid;
`else
    assign elig   = req_valid;
`endif

    assign pkt_chain[0] = '0;
    assign src_chain[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            // Thermometer mask of positions at or after the round-robin pointer
            assign at_or_above_ptr[gi] = (rr_ptr_reg <= SRC_W'(gi));
            assign pkt_chain[gi+1] = pkt_chain[gi]
                                   | ({PKT_W{grant_oh[gi]}} & req_pkt[gi*PKT_W +: PKT_W]);
            assign src_chain[gi+1] = src_chain[gi]
                                   | (grant_oh[gi] ? SRC_W'(gi) : '0);
        end
    endgenerate

    // Scan upward from rr_ptr; if nothing is found there, wrap to the lowest index
    assign elig_hi  = elig & at_or_above_ptr;
    assign pick_src = (|elig_hi) ? elig_hi : elig;
    assign grant_oh = pick_src & (~pick_src + NUM_REQ'(1));
    assign grant_any = |elig;

    assign winner  = src_chain[NUM_REQ];
    assign win_pkt = pkt_chain[NUM_REQ];
    assign win_wb  = |(grant_oh & req_wb);

    assign req_ack   = (rst || !cap_en) ? '0 : grant_oh;
    assign bank_full = req_valid & ~req_ack;

    // Pointer moves just past the winner, wrapping after the last requester
    always_comb begin
        rr_ptr_next = winner + SRC_W'(1);
        if (grant_oh[NUM_REQ-1]) begin
            rr_ptr_next = '0;
        end
    end

    // Output stage: capture the winner, or empty out when draining idle
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_pkt_reg   <= '0;
            out_src_reg   <= '0;
            out_wb_reg    <= 1'b0;
            rr_ptr_reg    <= '0;
        end else if (cap_en) begin
            if (grant_any) begin
                out_valid_reg <= 1'b1;
                out_pkt_reg   <= win_pkt;
                out_src_reg   <= winner;
                out_wb_reg    <= win_wb;
                rr_ptr_reg    <= rr_ptr_next;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_pkt   = out_pkt_reg;
    assign out_src   = out_src_reg;
    assign out_wb    = out_wb_reg;

endmodule

// File: tb/tb_ser_port_arb.sv
// Randomized scoreboard bench for ser_port_arb: a reference model picks the
// expected winner each cycle and queues the captured packet; a monitor pops
// and compares whenever a packet is handed to the serializer.
module tb_ser_port_arb;

    localparam int N     = 4;
    localparam int PKT_W = 160;
    localparam int SRC_W = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N-1:0]         req_valid = '0;
    logic [N-1:0]         req_wb = '0;
    logic [N*PKT_W-1:0]   req_pkt = '0;
    logic [N-1:0]         req_ack;
    logic [N-1:0]         bank_full;
    logic                 ser_full = 1'b1;
    logic                 out_valid;
    logic [PKT_W-1:0]     out_pkt;
    logic [SRC_W-1:0]     out_src;
    logic                 out_wb;

    ser_port_arb #(.NUM_REQ(N), .PKT_W(PKT_W), .SRC_W(SRC_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wb(req_wb), .req_pkt(req_pkt),
        .req_ack(req_ack), .bank_full(bank_full),
        .ser_full(ser_full),
        .out_valid(out_valid), .out_pkt(out_pkt), .out_src(out_src), .out_wb(out_wb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PKT_W-1:0] pkt;
        int               src;
        logic             wb;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    // Bank-side state: packet each bank is currently holding
    bit               bank_v  [N];
    bit               bank_wb [N];
    logic [PKT_W-1:0] bank_pkt[N];

    // Reference model state
    bit m_ov = 1'b0;
    int m_rr = 0;
    bit prev_rst = 1'b1;

    // Stimulus knobs
    int     p_req  = 100;
    logic [N-1:0] en_mask = '1;

    task automatic chk(input string name, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [PKT_W-1:0] rand_pkt();
        logic [PKT_W-1:0] p;
        p = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return p;
    endfunction

    // Round-robin pick straight from the arbitration rules
    function automatic int model_pick(input logic [N-1:0] v, input logic [N-1:0] w, input int rr);
        logic [N-1:0] m;
        m = v;
`ifdef SER_PORT_ARB_WB_PRIO_EN
        if ((v & w) != '0) m = v & w;
`else
        if (w === 'x) m = v;
`endif
        for (int k = 0; k < N; k++) begin
            int j;
            j = (rr + k) % N;
            if (m[j]) return j;
        end
        return -1;
    endfunction

    // One clock cycle: drive at negedge, check combinational outputs, advance model
    task automatic do_step(input bit r, input bit sf);
        logic [N-1:0] exp_ack;
        int w;
        @(negedge clk);
        rst      = r;
        ser_full = sf;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = bank_v[i];
            req_wb[i]    = bank_wb[i];
            req_pkt[i*PKT_W +: PKT_W] = bank_pkt[i];
        end
        #1;
        chk("out_valid", PKT_W'(out_valid), PKT_W'(m_ov));
        if (prev_rst) begin
            chk("rst_out_pkt", out_pkt, '0);
            chk("rst_out_src", PKT_W'(out_src), '0);
            chk("rst_out_wb", PKT_W'(out_wb), '0);
        end
        w = -1;
        if (!r && (!m_ov || !sf)) w = model_pick(req_valid, req_wb, m_rr);
        exp_ack = '0;
        if (w >= 0) exp_ack[w] = 1'b1;
        chk("req_ack", PKT_W'(req_ack), PKT_W'(exp_ack));
        chk("bank_full", PKT_W'(bank_full), PKT_W'(req_valid & ~exp_ack));

        if (r) begin
            m_ov = 1'b0;
            m_rr = 0;
            sb_q.delete();
        end else if (!m_ov || !sf) begin
            if (w >= 0) begin
                sb_q.push_back('{pkt: bank_pkt[w], src: w, wb: bank_wb[w]});
                m_ov = 1'b1;
                m_rr = (w + 1) % N;
            end else begin
                m_ov = 1'b0;
            end
        end
        prev_rst = r;

        // Banks react to the DUT's ack at this edge and may present new packets next cycle
        for (int i = 0; i < N; i++) begin
            if (req_ack[i]) bank_v[i] = 1'b0;
            if (!bank_v[i] && en_mask[i] && ($urandom_range(99) < p_req)) begin
                bank_v[i]   = 1'b1;
                bank_wb[i]  = $urandom_range(1);
                bank_pkt[i] = rand_pkt();
            end
        end
    endtask

    // Monitor: a transfer happens at the next edge when out_valid & ~ser_full
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst && out_valid && !ser_full) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got transfer src=%0d expected none", out_src);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("xfer src=%0d wb=%0d pkt=%h", out_src, out_wb, out_pkt);
                    chk("out_pkt", out_pkt, e.pkt);
                    chk("out_src", PKT_W'(out_src), PKT_W'(e.src));
                    chk("out_wb", PKT_W'(out_wb), PKT_W'(e.wb));
                end
            end
        end
    end

    initial begin
        int sf_pct;
        for (int i = 0; i < N; i++) begin
            bank_v[i]   = 1'b1;
            bank_wb[i]  = $urandom_range(1);
            bank_pkt[i] = rand_pkt();
        end
        // Reset sweep with every bank requesting
        do_step(1'b1, 1'b0);
        do_step(1'b1, 1'b0);
        // Full-throughput round robin
        for (int c = 0; c < 12; c++) do_step(1'b0, 1'b0);
        // Backpressure hold, then release
        for (int c = 0; c < 6; c++) do_step(1'b0, 1'b1);
        for (int c = 0; c < 4; c++) do_step(1'b0, 1'b0);
        // Randomized traffic with backpressure and occasional mid-operation resets
        sf_pct = 30;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) begin
                p_req   = ($urandom_range(2) == 0) ? 20 : (($urandom_range(1) == 0) ? 60 : 100);
                en_mask = N'($urandom_range(15));
                sf_pct  = $urandom_range(60);
            end
            if ($urandom_range(149) == 0) do_step(1'b1, 1'b1);
            else do_step(1'b0, $urandom_range(99) < sf_pct);
        end
        // Single requester: only bank 1 keeps requesting
        en_mask = 4'b0010;
        p_req   = 100;
        for (int c = 0; c < 40; c++) do_step(1'b0, 1'b0);
        // Drain everything
        en_mask = '0;
        for (int c = 0; c < 30; c++) do_step(1'b0, 1'b0);
        chk("sb_drained", PKT_W'(sb_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ser_port_arb.md
Name: ser_port_arb

Overview:
- Round-robin arbiter that shares one serializer (SERDES) input port between NUM_REQ cache-bank requesters, for example the extract/writeback streams of four cache banks.
- Each bank holds a packet stable until it is acknowledged.
- The arbiter captures one winner per cycle into a registered output stage that drains into the serializer under its FULL backpressure.
- It also returns per-bank full indications that the banks use as their SER*_FULL inputs.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8
PKT_W, 160, packet width in bits (data + pAddress + return/size/rw/dest fields, packed by the bank)
SRC_W, 2, source-ID width; must satisfy 2^SRC_W >= NUM_REQ

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  NUM_REQ  bit i: bank i has a packet pending
req_wb  input  NUM_REQ  bit i: bank i's packet is a writeback/extract (1) or read (0)
req_pkt  input  NUM_REQ*PKT_W  bank i's packet at bits [i*PKT_W +: PKT_W]
req_ack  output  NUM_REQ  one-hot or zero; combinational; bit i high in the cycle bank i's packet is captured
bank_full  output  NUM_REQ  bit i = req_valid[i] & ~req_ack[i]; feeds the bank's SER_FULL
ser_full  input  1  serializer cannot accept this cycle
out_valid  output  1  output register holds a packet
out_pkt  output  PKT_W  registered packet to serializer
out_src  output  SRC_W  index of the bank that supplied out_pkt
out_wb  output  1  registered req_wb of the captured packet

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset state: out_valid=0, out_pkt=0, out_src=0, out_wb=0, rr_ptr=0. req_ack=0 while rst=1.
- Transfer to the serializer: occurs on a rising edge where out_valid=1 and ser_full=0.
- Capture enable: cap_en = ~out_valid | ~ser_full, meaning the output register is empty or is draining this cycle.
- Arbitration:
  - Active only when cap_en=1 and at least one req_valid bit is set.
  - Scan starts at index rr_ptr and proceeds upward, wrapping modulo NUM_REQ.
  - The first set req_valid bit wins; req_ack[winner]=1 in that same cycle.
- Capture: on that edge, out_pkt <= req_pkt[winner], out_src <= winner, out_wb <= req_wb[winner], out_valid <= 1, and rr_ptr <= winner+1.
  - When winner = NUM_REQ-1, rr_ptr wraps to 0.
- Drain with nothing to capture: if cap_en=1 and no request is pending, a transfer clears out_valid.
  - rr_ptr, out_pkt, out_src and out_wb hold their values.
- Back-to-back operation: with ser_full=0 continuously, one packet is captured and one transferred per cycle, giving full throughput.
  - Latency from request to out_valid is 1 cycle.
- Backpressure:
  - While out_valid=1 and ser_full=1, cap_en=0.
  - Under that condition req_ack=0, and out_* and rr_ptr hold.
- Requester protocol:
  - The bank keeps req_valid, req_wb and req_pkt stable until it samples req_ack=1 at a clock edge.
  - The bank may present a new packet in the following cycle.
  - The arbiter never acks a requester whose req_valid is 0.
- Fairness: a requester continuously asserting req_valid is granted within NUM_REQ captures.
- Single-requester case: when only one bank is active, it is granted on every cap_en cycle, independent of rr_ptr.
- Reset mid-operation: a packet held in the output register is discarded and is not transferred. Pending bank requests remain asserted and are arbitrated normally from rr_ptr=0 after reset.
- Combinational path: req_ack and bank_full depend combinationally on req_valid, out_valid, ser_full and rr_ptr.
  - No combinational path exists from req_pkt to any output.

Optional Feature:
- Macro SER_PORT_ARB_WB_PRIO_EN.
- When defined, arbitration is two-class:
  - If any requester has req_valid & req_wb set, the round-robin scan considers only those requesters.
  - Otherwise all valid requesters are considered.
  - rr_ptr is one shared pointer, updated after every grant of either class.
  - Writebacks therefore free cache lines ahead of read misses.
- When undefined, req_wb is ignored for arbitration and is only carried through to out_wb; arbitration is pure round-robin.

Test Plan:
- Reset sweep: assert rst for 2 cycles with all req_valid=4'b1111 → out_valid=0, req_ack=0, out_src=0; in the first cycle after rst drops, req_ack=4'b0001.
- Round-robin: req_valid=4'b1111 held, ser_full=0, each bank reasserts after its ack → out_src sequence 0,1,2,3,0 on consecutive cycles; bank_full is 1 for the three non-acked banks each cycle.
- Backpressure: capture bank 2 (pkt=0xA5...), then ser_full=1 for 5 cycles with req_valid=4'b1001 → out_pkt stable at bank 2's packet, req_ack=0, bank_full=4'b1001; ser_full drops → the same edge transfers and captures bank 3 (rr_ptr=3).
- Wrap and single requester: rr_ptr=3 and req_valid=4'b0010 → bank 1 granted; next rr_ptr=2; grant repeats every cycle while held.
- Mid-operation reset: out_valid=1, ser_full=1, pulse rst for 1 cycle → out_valid=0 after the edge; no transfer edge (out_valid & ~ser_full) occurs for that packet.
- SER_PORT_ARB_WB_PRIO_EN defined: rr_ptr=0, req_valid=4'b0111, req_wb=4'b0100 → bank 2 granted first, then bank 0. Same stimulus with the macro undefined → bank 0 granted first.
